call_stack: RTL and testbench

Parametrised hardware return-address stack for the CPU control path. It stores the return PC on a subroutine call and supplies it on return. It replaces the edge-triggered 10-entry stack with a fully synchronous single-clock design. New over the old block: configurable width and depth, simultaneous push/pop (replace-top), flush, occupancy count, and sticky overflow/underflow error flags.

---
 rtl/call_stack.sv | 111 +++++++++++
 tb/tb_call_stack.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Return-address stack for the CPU control path: push/pop/replace-top with
// flush, occupancy count and sticky overflow/underflow flags.
module call_stack #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_FLUSH,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_OVERFLOW,
    OP_UNDERFLOW
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  op_e              op;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             mem_we;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top_idx = AW'(count - CW'(1));

  // One operation per edge; push+pop on an empty stack degrades to a plain push.
  always_comb begin
    op = OP_HOLD;
    if (flush) begin
      op = OP_FLUSH;
    end else if (push && pop) begin
      op = empty ? OP_PUSH : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_OVERFLOW : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_UNDERFLOW : OP_POP;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    wr_idx = '0;
    case (op)
      OP_PUSH: begin
        mem_we = 1'b1;
        wr_idx = AW'(count);
      end
      OP_REPLACE: begin
        mem_we = 1'b1;
        wr_idx = top_idx;
      end
      default: begin
        mem_we = 1'b0;
        wr_idx = '0;
      end
    endcase
  end

  // Storage is deliberately not reset; entries at or above count are never shown.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case (op)
        OP_FLUSH: count <= '0;
        OP_PUSH:  count <= count + CW'(1);
        OP_POP:   count <= count - CW'(1);
        default:  count <= count;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (op == OP_OVERFLOW);
      underflow <= (underflow & ~clr_err) | (op == OP_UNDERFLOW);
    end
  end

  assign dout = empty ? '0 : mem[top_idx];

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: a 16x10 and a 4x8 instance share stimulus and are
// compared against queue-based reference stacks after every edge.
module tb_call_stack;

  localparam int WA = 10;
  localparam int DA = 16;
  localparam int WB = 8;
  localparam int DB = 4;
  localparam int CA = $clog2(DA + 1);
  localparam int CB = $clog2(DB + 1);

  typedef int stack_q[$];

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic          flush;
  logic          clr_err;
  logic [WA-1:0] din_a;
  logic [WB-1:0] din_b;
  logic [WA-1:0] dout_a;
  logic [WB-1:0] dout_b;
  logic [CA-1:0] count_a;
  logic [CB-1:0] count_b;
  logic          empty_a, full_a, overflow_a, underflow_a;
  logic          empty_b, full_b, overflow_b, underflow_b;

  stack_q model_a;
  stack_q model_b;
  bit     ovf_a, unf_a, ovf_b, unf_b;
  int     checks;
  int     errors;

  call_stack #(.WIDTH(WA), .DEPTH(DA)) dut_a (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .din(din_a), .dout(dout_a), .count(count_a),
    .empty(empty_a), .full(full_a), .overflow(overflow_a), .underflow(underflow_a)
  );

  call_stack #(.WIDTH(WB), .DEPTH(DB)) dut_b (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .din(din_b), .dout(dout_b), .count(count_b),
    .empty(empty_b), .full(full_b), .overflow(overflow_b), .underflow(underflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stack behaviour expressed directly on a queue.
  function automatic stack_q model_next(stack_q q, int depth, bit p, bit po, bit fl, int d);
    stack_q r = q;
    if (fl) begin
      r.delete();
    end else if (p && po) begin
      if (r.size() == 0) r.push_back(d);
      else r[r.size()-1] = d;
    end else if (p) begin
      if (r.size() < depth) r.push_back(d);
    end else if (po) begin
      if (r.size() > 0) void'(r.pop_back());
    end
    return r;
  endfunction

  function automatic int model_top(stack_q q);
    return (q.size() == 0) ? 0 : q[q.size()-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("a.count",     32'(count_a),     model_a.size());
    check("a.dout",      32'(dout_a),      model_top(model_a));
    check("a.empty",     32'(empty_a),     32'(model_a.size() == 0));
    check("a.full",      32'(full_a),      32'(model_a.size() == DA));
    check("a.overflow",  32'(overflow_a),  32'(ovf_a));
    check("a.underflow", 32'(underflow_a), 32'(unf_a));
    check("b.count",     32'(count_b),     model_b.size());
    check("b.dout",      32'(dout_b),      model_top(model_b));
    check("b.empty",     32'(empty_b),     32'(model_b.size() == 0));
    check("b.full",      32'(full_b),      32'(model_b.size() == DB));
    check("b.overflow",  32'(overflow_b),  32'(ovf_b));
    check("b.underflow", 32'(underflow_b), 32'(unf_b));
  endtask

  task automatic reset_model();
    model_a.delete();
    model_b.delete();
    ovf_a = 0; unf_a = 0; ovf_b = 0; unf_b = 0;
  endtask

  // Drive one cycle of stimulus, advance the models across the edge, then compare.
  task automatic apply_stimulus(input bit p, input bit po, input bit fl, input bit ce,
                                input logic [WA-1:0] d);
    push = p; pop = po; flush = fl; clr_err = ce;
    din_a = d;
    din_b = d[WB-1:0];
    @(posedge clk);
    ovf_a = (ovf_a && !ce) || (!fl && p && !po && model_a.size() == DA);
    unf_a = (unf_a && !ce) || (!fl && po && !p && model_a.size() == 0);
    ovf_b = (ovf_b && !ce) || (!fl && p && !po && model_b.size() == DB);
    unf_b = (unf_b && !ce) || (!fl && po && !p && model_b.size() == 0);
    model_a = model_next(model_a, DA, p, po, fl, int'(d));
    model_b = model_next(model_b, DB, p, po, fl, int'(d[WB-1:0]));
    #1;
    check_output();
  endtask

  // Pull reset low between edges and confirm the reset state before the next edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    reset_model();
    check_output();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    push = 0; pop = 0; flush = 0; clr_err = 0;
    din_a = '0; din_b = '0;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] fill");
    for (int i = 1; i <= DA; i++) apply_stimulus(1, 0, 0, 0, WA'(i));
    check("fill.dout", 32'(dout_a), 32'h010);
    check("fill.full", 32'(full_a), 32'd1);

    $display("[TB] overflow");
    apply_stimulus(1, 0, 0, 0, 10'h3FF);
    check("ovf.flag", 32'(overflow_a), 32'd1);
    check("ovf.dout", 32'(dout_a), 32'h010);
    apply_stimulus(0, 0, 0, 1, 10'h000);
    check("ovf.clear", 32'(overflow_a), 32'd0);

    $display("[TB] drain and underflow");
    for (int i = 0; i < DA; i++) apply_stimulus(0, 1, 0, 0, 10'h000);
    apply_stimulus(0, 1, 0, 0, 10'h000);
    check("unf.flag", 32'(underflow_a), 32'd1);
    apply_stimulus(0, 1, 0, 1, 10'h000);
    check("unf.set_wins", 32'(underflow_a), 32'd1);
    apply_stimulus(0, 0, 0, 1, 10'h000);

    $display("[TB] replace-top");
    apply_stimulus(1, 0, 0, 0, 10'h100);
    apply_stimulus(1, 0, 0, 0, 10'h200);
    apply_stimulus(1, 1, 0, 0, 10'h2AA);
    check("rep.dout", 32'(dout_a), 32'h2AA);
    check("rep.count", 32'(count_a), 32'd2);
    apply_stimulus(0, 1, 0, 0, 10'h000);
    check("rep.pop", 32'(dout_a), 32'h100);
    apply_stimulus(0, 1, 0, 0, 10'h000);
    apply_stimulus(1, 1, 0, 0, 10'h155);
    check("rep.empty_push", 32'(dout_a), 32'h155);
    check("rep.no_unf", 32'(underflow_a), 32'd0);

    $display("[TB] flush priority");
    apply_stimulus(0, 0, 1, 0, 10'h000);
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, WA'(10'h040 + i));
    apply_stimulus(1, 1, 1, 0, 10'h077);
    check("flush.empty", 32'(empty_a), 32'd1);
    apply_stimulus(1, 0, 0, 0, 10'h011);
    check("flush.push", 32'(dout_a), 32'h011);

    $display("[TB] async reset mid-run");
    apply_stimulus(0, 0, 1, 0, 10'h000);
    for (int i = 0; i < 7; i++) apply_stimulus(1, 0, 0, 0, WA'(10'h0A0 + i));
    check("ar.b_ovf_before", 32'(overflow_b), 32'd1);
    async_reset();
    apply_stimulus(1, 0, 0, 0, 10'h3C3);

    $display("[TB] random");
    for (int n = 0; n < 400; n++) begin
      bit p, po, fl, ce;
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      ce = ($urandom_range(0, 9) == 0);
      apply_stimulus(p, po, fl, ce, WA'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
